mfp_spi_arbiter_sequencer: RTL

- Shares one SPI bus (SCLK/MOSI/MISO) between N_REQ requesters, for example the CPU SPI peripheral and a periodic light-sensor poller.
- Arbitrates round-robin, latches the winner's command and drives that requester's dedicated active-low chip select.
- Sequences the CS setup, bit-shift and CS hold phases in SPI mode 0, then returns the received word to the winner.
- Instantiated inside mfp_system between the AHB-Lite SPI peripherals and the board Pmod pins.

---
 rtl/mfp_spi_arbiter_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mfp_spi_arbiter_sequencer.sv
// Shares one SPI mode-0 bus among N_REQ requesters, each with its own active-low chip select.
// Arbitration is round-robin by default; define MFP_SPI_ARB_FIXED_PRIORITY_EN for lowest-index-wins.
//
// state | meaning
// IDLE  | no transaction; a set req is arbitrated and granted on the next edge
// SETUP | CS low, SCLK low, MSB presented on MOSI for CS_SETUP cycles
// XFER  | per bit: CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high
// HOLD  | CS still low for CS_HOLD cycles after the last SCLK fall
// GAP   | all CS high, busy still set for CS_HOLD cycles before re-arbitration
module mfp_spi_arbiter_sequencer #(
  parameter int N_REQ    = 2,
  parameter int MAX_BITS = 16,
  parameter int CLK_DIV  = 25,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4
) (
  input  logic                        SI_ClkIn,
  input  logic                        SI_Reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*5-1:0]          req_len,
  input  logic [N_REQ*MAX_BITS-1:0]   req_tx,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic [MAX_BITS-1:0]         rx_data,
  output logic                        busy,
  output logic                        SPI_SCLK,
  output logic                        SPI_MOSI,
  input  logic                        SPI_MISO,
  output logic [N_REQ-1:0]            SPI_CS_N
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW   = $clog2(MAX_BITS);
  localparam int CMAX = (CLK_DIV > CS_SETUP) ?
                        ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                        ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bit_idx;
  logic [MAX_BITS-1:0] tx_lat;
  logic [MAX_BITS-1:0] rx_sh;

  logic                win_valid;
  logic [N_REQ-1:0]    win_oh;
  logic [PW-1:0]       win_idx;
  logic [4:0]          win_len;
  logic [MAX_BITS-1:0] win_tx;
  logic [BW-1:0]       win_top;

  // Winner search starts at the pointer and wraps; the first set req found wins.
  always_comb begin
    int j;
    int len_i;
    j         = 0;
    len_i     = 0;
    win_valid = 1'b0;
    win_oh    = '0;
    win_idx   = '0;
    win_len   = '0;
    win_tx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef MFP_SPI_ARB_FIXED_PRIORITY_EN
      j = i;
`else
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
`endif
      if (req[j] && !win_valid) begin
        win_valid = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = PW'(j);
        win_len   = req_len[j*5 +: 5];
        win_tx    = req_tx[j*MAX_BITS +: MAX_BITS];
      end
    end
    len_i = int'(win_len);
    if (len_i == 0 || len_i > MAX_BITS) len_i = MAX_BITS;
    win_top = BW'(len_i - 1);
  end

  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      tx_lat   <= '0;
      rx_sh    <= '0;
      gnt      <= '0;
      done     <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      SPI_SCLK <= 1'b0;
      SPI_MOSI <= 1'b0;
      SPI_CS_N <= '1;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (win_valid) begin
            gnt      <= win_oh;
            SPI_CS_N <= ~win_oh;
            busy     <= 1'b1;
            tx_lat   <= win_tx;
            bit_idx  <= win_top;
            rx_sh    <= '0;
            SPI_MOSI <= win_tx[win_top];
            ptr      <= (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            cnt      <= CW'(CS_SETUP - 1);
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt   <= CW'(CLK_DIV - 1);
            state <= XFER;
          end
        end
        XFER: begin
          // SCLK itself marks which half of the bit period is running.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!SPI_SCLK) begin
            SPI_SCLK <= 1'b1;
            rx_sh    <= {rx_sh[MAX_BITS-2:0], SPI_MISO};
            cnt      <= CW'(CLK_DIV - 1);
          end else begin
            SPI_SCLK <= 1'b0;
            if (bit_idx == '0) begin
              SPI_MOSI <= 1'b0;
              cnt      <= CW'(CS_HOLD - 1);
              state    <= HOLD;
            end else begin
              bit_idx  <= bit_idx - 1'b1;
              SPI_MOSI <= tx_lat[bit_idx - 1'b1];
              cnt      <= CW'(CLK_DIV - 1);
            end
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            SPI_CS_N <= '1;
            gnt      <= '0;
            done     <= gnt;
            rx_data  <= rx_sh;
            cnt      <= CW'(CS_HOLD - 1);
            state    <= GAP;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
